// File: rtl/mem_wb_pipeline_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_pipeline_reg
//
// MEM/WB pipeline register of the RV32IM five-stage pipeline. Captures the
// memory-stage results on each rising clock edge and holds them for the
// write-back stage. Also selects the write-back data, which the forwarding
// unit can observe as well.
//
// Update priority on a rising edge (with Reset high): Flush > Stall > capture.
//   Flush : load a bubble (every field zero), regardless of Stall
//   Stall : every field keeps its value
//   else  : every field takes its input as sampled at the edge
//
// Ports
//   CLK                clock, all state updates on the rising edge
//   Reset              asynchronous active-low reset, clears all state
//   Stall              hold all registered outputs
//   Flush              insert a bubble on the next edge
//   Write_enable       register-file write enable from MEM
//   Memory_access      instruction is a load (write-back takes memory data)
//   Memory_Data        data read from data memory
//   ALU_Output         ALU / address result from MEM
//   Write_Address      destination register rd
//   Write_Enable_Out   registered write enable (forced low for rd == x0)
//   Memory_access_Out  registered load flag
//   Memory_Data_Out    registered memory data
//   ALU_Output_Out     registered ALU result
//   Write_Address_out  registered rd (captured unchanged, even for x0)
//   Write_Data_Out     combinational write-back data select
// ---------------------------------------------------------------------------
module mem_wb_pipeline_reg #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      Write_enable,
  input  logic                      Memory_access,
  input  logic [DATA_WIDTH-1:0]     Memory_Data,
  input  logic [DATA_WIDTH-1:0]     ALU_Output,
  input  logic [REG_ADDR_WIDTH-1:0] Write_Address,
  output logic                      Write_Enable_Out,
  output logic                      Memory_access_Out,
  output logic [DATA_WIDTH-1:0]     Memory_Data_Out,
  output logic [DATA_WIDTH-1:0]     ALU_Output_Out,
  output logic [REG_ADDR_WIDTH-1:0] Write_Address_out,
  output logic [DATA_WIDTH-1:0]     Write_Data_Out
);

  // -------------------------------------------------------------------------
  // Pipeline state
  // -------------------------------------------------------------------------
  logic                      wr_en_q,    wr_en_d;
  logic                      mem_acc_q,  mem_acc_d;
  logic [DATA_WIDTH-1:0]     mem_data_q, mem_data_d;
  logic [DATA_WIDTH-1:0]     alu_q,      alu_d;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;

  // Writes to x0 are architecturally discarded; dropping the enable here keeps
  // the register file and the forwarding unit from ever seeing an x0 write.
  logic wr_addr_nonzero;
  logic wr_en_qualified;

  assign wr_addr_nonzero = |Write_Address;
  assign wr_en_qualified = Write_enable & wr_addr_nonzero;

  // -------------------------------------------------------------------------
  // Next-state selection: bubble, hold or capture
  // -------------------------------------------------------------------------
  always_comb begin
    // Default: capture the MEM-stage values.
    wr_en_d    = wr_en_qualified;
    mem_acc_d  = Memory_access;
    mem_data_d = Memory_Data;
    alu_d      = ALU_Output;
    wr_addr_d  = Write_Address;

    if (Flush) begin
      // A bubble has no side effects: all fields cleared.
      wr_en_d    = 1'b0;
      mem_acc_d  = 1'b0;
      mem_data_d = '0;
      alu_d      = '0;
      wr_addr_d  = '0;
    end else if (Stall) begin
      wr_en_d    = wr_en_q;
      mem_acc_d  = mem_acc_q;
      mem_data_d = mem_data_q;
      alu_d      = alu_q;
      wr_addr_d  = wr_addr_q;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wr_en_q    <= 1'b0;
      mem_acc_q  <= 1'b0;
      mem_data_q <= '0;
      alu_q      <= '0;
      wr_addr_q  <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      mem_acc_q  <= mem_acc_d;
      mem_data_q <= mem_data_d;
      alu_q      <= alu_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign Write_Enable_Out  = wr_en_q;
  assign Memory_access_Out = mem_acc_q;
  assign Memory_Data_Out   = mem_data_q;
  assign ALU_Output_Out    = alu_q;
  assign Write_Address_out = wr_addr_q;

  // Driven only from registered values, so it moves only when state moves.
  always_comb begin
    Write_Data_Out = alu_q;
    if (mem_acc_q) begin
      Write_Data_Out = mem_data_q;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipeline_reg.sv
// Self-checking bench for mem_wb_pipeline_reg: directed cases with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model of the MEM/WB stage.
module tb_mem_wb_pipeline_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          Stall, Flush;
  logic          Write_enable, Memory_access;
  logic [DW-1:0] Memory_Data, ALU_Output;
  logic [AW-1:0] Write_Address;
  logic          Write_Enable_Out, Memory_access_Out;
  logic [DW-1:0] Memory_Data_Out, ALU_Output_Out, Write_Data_Out;
  logic [AW-1:0] Write_Address_out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  mem_wb_pipeline_reg #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW)
  ) dut (
    .CLK               (CLK),
    .Reset             (Reset),
    .Stall             (Stall),
    .Flush             (Flush),
    .Write_enable      (Write_enable),
    .Memory_access     (Memory_access),
    .Memory_Data       (Memory_Data),
    .ALU_Output        (ALU_Output),
    .Write_Address     (Write_Address),
    .Write_Enable_Out  (Write_Enable_Out),
    .Memory_access_Out (Memory_access_Out),
    .Memory_Data_Out   (Memory_Data_Out),
    .ALU_Output_Out    (ALU_Output_Out),
    .Write_Address_out (Write_Address_out),
    .Write_Data_Out    (Write_Data_Out)
  );

  // Behavioural model: the instruction currently presented to write-back.
  typedef struct {
    bit          we;
    bit          ld;
    bit [DW-1:0] md;
    bit [DW-1:0] alu;
    bit [AW-1:0] rd;
  } wb_t;

  wb_t m;

  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      m = '{default: 0};
    end else if (Flush) begin
      m = '{default: 0};
    end else if (!Stall) begin
      m.we  = Write_enable && (Write_Address != 0);
      m.ld  = Memory_access;
      m.md  = Memory_Data;
      m.alu = ALU_Output;
      m.rd  = Write_Address;
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".we"},    DW'(Write_Enable_Out),  DW'(m.we));
    check({tag, ".ld"},    DW'(Memory_access_Out), DW'(m.ld));
    check({tag, ".md"},    Memory_Data_Out,        m.md);
    check({tag, ".alu"},   ALU_Output_Out,         m.alu);
    check({tag, ".rd"},    DW'(Write_Address_out), DW'(m.rd));
    check({tag, ".wdata"}, Write_Data_Out,         m.ld ? m.md : m.alu);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".we"},    DW'(Write_Enable_Out),  '0);
    check({tag, ".ld"},    DW'(Memory_access_Out), '0);
    check({tag, ".md"},    Memory_Data_Out,        '0);
    check({tag, ".alu"},   ALU_Output_Out,         '0);
    check({tag, ".rd"},    DW'(Write_Address_out), '0);
    check({tag, ".wdata"}, Write_Data_Out,         '0);
  endtask

  // Per-cycle comparison, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) check_model("cycle");
  end

  task automatic drive(input bit we, input bit ld, input bit [DW-1:0] md,
                       input bit [DW-1:0] alu, input bit [AW-1:0] rd,
                       input bit st, input bit fl);
    Write_enable  = we;
    Memory_access = ld;
    Memory_Data   = md;
    ALU_Output    = alu;
    Write_Address = rd;
    Stall         = st;
    Flush         = fl;
  endtask

  task automatic mid_cycle;
    @(negedge CLK);
    #1;
  endtask

  task automatic after_edge;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset held low with non-zero inputs: outputs zero before any edge.
    Reset = 1'b0;
    drive(1, 1, 32'hFFFF_0000, 32'h5A5A5A5A, 5'd9, 0, 0);
    #3;
    check_zero("reset_pre_edge");
    after_edge;
    after_edge;
    check_zero("reset_across_edges");

    // First capture after release: load, write-back takes memory data.
    mid_cycle;
    Reset = 1'b1;
    chk_en = 1'b1;
    drive(1, 1, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'b10101, 0, 0);
    after_edge;
    check("v1.wdata", Write_Data_Out, 32'hA5A5A5A5);
    check("v1.rd", DW'(Write_Address_out), 32'd21);
    check("v1.we", DW'(Write_Enable_Out), 32'd1);

    // Second vector: old values held until the edge.
    mid_cycle;
    drive(0, 0, 32'h12345678, 32'h87654321, 5'b11111, 0, 0);
    #1;
    check("v2.pre_edge_wdata", Write_Data_Out, 32'hA5A5A5A5);
    after_edge;
    check("v2.wdata", Write_Data_Out, 32'h87654321);
    check("v2.md", Memory_Data_Out, 32'h12345678);
    check("v2.we", DW'(Write_Enable_Out), 32'd0);
    check("v2.rd", DW'(Write_Address_out), 32'd31);

    // Asynchronous reset between edges, then capture on the next edge.
    mid_cycle;
    drive(1, 0, 32'h00001111, 32'h00002222, 5'd3, 0, 0);
    Reset = 1'b0;
    #1;
    check_zero("async_reset");
    #1;
    Reset = 1'b1;
    after_edge;
    check("rel.alu", ALU_Output_Out, 32'h00002222);
    check("rel.wdata", Write_Data_Out, 32'h00002222);
    check("rel.we", DW'(Write_Enable_Out), 32'd1);

    // Stall for two edges with changing inputs.
    mid_cycle;
    drive(0, 1, 32'hDEAD0001, 32'hBEEF0001, 5'd7, 1, 0);
    after_edge;
    mid_cycle;
    drive(1, 1, 32'hDEAD0002, 32'hBEEF0002, 5'd8, 1, 0);
    after_edge;
    check("stall.alu", ALU_Output_Out, 32'h00002222);
    check("stall.rd", DW'(Write_Address_out), 32'd3);
    check("stall.ld", DW'(Memory_access_Out), 32'd0);

    // Flush wins over stall.
    mid_cycle;
    drive(1, 1, 32'hCAFE0000, 32'hF00D0000, 5'd12, 1, 1);
    after_edge;
    check_zero("flush_over_stall");

    // Write to x0: enable suppressed, address and data captured.
    mid_cycle;
    drive(1, 0, 32'h0, 32'h00000010, 5'd0, 0, 0);
    after_edge;
    check("x0.we", DW'(Write_Enable_Out), 32'd0);
    check("x0.alu", ALU_Output_Out, 32'h00000010);
    check("x0.rd", DW'(Write_Address_out), 32'd0);

    // Randomized traffic; the per-cycle compare process checks each cycle.
    for (int i = 0; i < 400; i++) begin
      mid_cycle;
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
            ($urandom_range(0, 5) == 0) ? 5'd0 : AW'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) begin
        Reset = 1'b0;
        #1;
        check_zero("rand_async_reset");
        if ($urandom_range(0, 1) == 0) begin
          #1;
          Reset = 1'b1;
        end
      end else begin
        Reset = 1'b1;
      end
    end

    mid_cycle;
    Reset = 1'b1;
    after_edge;
    check_model("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipeline_reg.md
Name: mem_wb_pipeline_reg

Overview:
- MEM/WB pipeline register of the RV32IM 5-stage pipeline.
- Captures the memory-stage results on each rising clock edge and presents them to write-back for one cycle: load data, ALU result, destination register, and control bits.
- Also provides a combinational write-back data select and a write-back forwarding view.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_WIDTH, 32, width of data/ALU paths.
- REG_ADDR_WIDTH, 5, width of register-file address.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Stall  input  1  1 = hold all registered outputs.
- Flush  input  1  1 = load a bubble on next edge.
- Write_enable  input  1  register-file write enable from MEM stage.
- Memory_access  input  1  1 = instruction is a load (write-back takes memory data).
- Memory_Data  input  DATA_WIDTH  data read from data memory.
- ALU_Output  input  DATA_WIDTH  ALU/address result from MEM stage.
- Write_Address  input  REG_ADDR_WIDTH  destination register rd.
- Write_Enable_Out  output  1  registered write enable.
- Memory_access_Out  output  1  registered load flag.
- Memory_Data_Out  output  DATA_WIDTH  registered memory data.
- ALU_Output_Out  output  DATA_WIDTH  registered ALU result.
- Write_Address_out  output  REG_ADDR_WIDTH  registered rd.
- Write_Data_Out  output  DATA_WIDTH  combinational: Memory_access_Out ? Memory_Data_Out : ALU_Output_Out.

Behaviour:
- Reset low (asynchronous, independent of CLK): all registered outputs become 0 immediately.
  - Write_Enable_Out=0, Memory_access_Out=0, Memory_Data_Out=0, ALU_Output_Out=0, Write_Address_out=0.
  - Write_Data_Out=0 as a consequence.
  - Outputs stay 0 while Reset is low; clock edges are ignored.
- Reset high, rising CLK edge, priority Flush > Stall > load:
  - Flush=1: load a bubble (all outputs 0), regardless of Stall.
  - Stall=1, Flush=0: all outputs hold their previous values.
  - Otherwise: each output takes its corresponding input as sampled at the edge.
- Latency: exactly one cycle from input to output; no combinational path from inputs to registered outputs.
- x0 suppression: Write_Enable_Out is loaded with Write_enable AND (Write_Address != 0). Write_Address_out still captures the address unchanged.
- Write_Data_Out: purely combinational mux on registered values; it changes only when registers change.
- Reset release: the first rising edge with Reset high performs a normal capture.
- Reset asserted mid-operation: state clears immediately; the in-flight instruction is lost.
- Inputs changing between edges have no effect on outputs.
- No X propagation: all state bits are defined after the first reset.

Test Plan:
- Reset=0 with inputs nonzero (Write_enable=1, ALU_Output=32'h5A5A5A5A) -> all outputs 0 before any clock edge. They remain 0 across edges while Reset=0.
- Reset=1; apply Write_enable=1, Memory_access=1, Memory_Data=32'hA5A5A5A5, ALU_Output=32'h5A5A5A5A, Write_Address=5'b10101; one edge -> outputs mirror inputs, Write_Data_Out=32'hA5A5A5A5.
- Next cycle apply Write_enable=0, Memory_access=0, Memory_Data=32'h12345678, ALU_Output=32'h87654321, Write_Address=5'b11111 -> after the edge outputs mirror these values and Write_Data_Out=32'h87654321. Before the edge the previous values are still held.
- Drive Reset=0 mid-cycle (between edges) -> outputs clear to 0 at once. Release Reset -> the next edge captures the current inputs.
- Stall=1 for 2 edges with changing inputs -> outputs frozen. Stall=1 and Flush=1 together -> outputs 0 after the edge.
- Write_enable=1, Write_Address=0, ALU_Output=32'h00000010 -> Write_Enable_Out=0, ALU_Output_Out=32'h00000010, Write_Address_out=0.
